reg_write_arbiter: RTL
======================

// Module: reg_write_arbiter
// PURPOSE
//  Shares the register file's single write port (IN/INaddr) between two writeback
//  requesters: the ALU result path and the memory-load path.
//  Each requester has a one-entry holding slot with a valid/ready handshake.
//  A round-robin arbiter, with same-address ordering protection, picks one slot per cycle.
//  Drives registered WRITE/INaddr/IN into reg_file, which commits on the following negedge.
//  Exports a pending-write bitmap so decode can stall on RAW hazards.
// PARAMETERS
//  DATA_W  8  register data width
//  ADDR_W  3  register address width
//  NREG    8  number of registers (2**ADDR_W)
// PORTS
//  clk           in   1       single clock; all state updates on posedge
//  RESET         in   1       synchronous, active-low reset
//  alu_valid     in   1       ALU writeback request
//  alu_ready     out  1       ALU slot can accept this cycle
//  alu_addr      in   ADDR_W  ALU destination register
//  alu_data      in   DATA_W  ALU result
//  mem_valid     in   1       load writeback request
//  mem_ready     out  1       MEM slot can accept this cycle
//  mem_addr      in   ADDR_W  load destination register
//  mem_data      in   DATA_W  load data
//  WRITE         out  1       write enable to reg_file
//  INaddr        out  ADDR_W  write address to reg_file
//  IN            out  DATA_W  write data to reg_file
//  pending       out  NREG    bit r=1 while a write to r is held or being output
//  conflict_cnt  out  8       saturating count of cycles with both slots occupied
// BEHAVIOUR
//  Reset (RESET==0 at posedge):
//   - Both slots are emptied.
//   - WRITE=0, INaddr=0, IN=0, pending=0, conflict_cnt=0.
//   - The round-robin pointer is set so ALU wins the first contested grant.
//   - Held requests are dropped; no write is emitted in the cycle after reset.
//   - alu_ready and mem_ready are 0 while RESET==0.
//  Handshake:
//   - xxx_ready = !slot_v | slot_granted_this_cycle (combinational).
//   - Transfer occurs on valid&ready at posedge.
//   - Requesters hold addr/data stable while valid is high and ready is low.
//  Grant, evaluated each cycle over occupied slots:
//   - One slot occupied: grant it.
//   - Both occupied, different addr: grant the slot not granted last (round-robin).
//   - Both occupied, same addr: grant the older slot (age bit).
//   - Simultaneous capture to the same addr: MEM is treated as older, so ALU's value survives.
//   - The granted slot clears at posedge, unless refilled at that same posedge.
//  Output stage:
//   - At the grant posedge: WRITE<=1, INaddr<=slot addr, IN<=slot data; otherwise WRITE<=0.
//   - Latency: capture at edge N, grant during N..N+1, WRITE high N+1..N+2,
//     reg_file commit at the negedge in that window.
//   - Uncontested throughput is 1 write per cycle.
//  pending:
//   - OR of decoded slot addresses (valid slots) and the output-stage addr when WRITE=1.
//   - Registered view; updates at posedge.
//  conflict_cnt increments each cycle both slots are occupied; saturates at 255.
//  No request is ever lost or reordered against a same-address request.
// STRUCTURE
//  Package reg_arb_pkg:
//   - Constants: DATA_W, ADDR_W, NREG.
//   - Requester enum: REQ_ALU=0, REQ_MEM=1.
//   - Typedef wb_req_t {addr, data}.
//  Sub-module wb_hold_slot, instantiated twice:
//   - One-entry register, valid bit, ready logic, clear-on-grant, age input.
//  The top holds the arbiter, age/round-robin state, output stage, pending decode and counter.
// TESTING
//  1. Reset: RESET=0 for 2 cycles with valids high -> WRITE=0, pending=0, readys=0;
//     release -> readys=1.
//  2. Single ALU write: alu addr=5 data=0xB7 -> WRITE=1, INaddr=5, IN=0xB7 one cycle later;
//     pending[5] set then clears.
//  3. Contention, different addrs: alu 1/0x11 and mem 2/0x22 same edge -> ALU written first,
//     then MEM; conflict_cnt=1.
//  4. Same-address: mem 3/0x33 and alu 3/0x44 same edge -> writes 0x33 then 0x44;
//     reg 3 final value = 0x44.
//  5. Back-to-back ALU 4 writes with mem idle -> 4 WRITE pulses on consecutive cycles,
//     alu_ready stays 1.
//  6. Reset mid-operation: both slots full, RESET=0 -> next cycle WRITE=0, pending=0,
//     no stale write afterwards.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared widths, requester identifiers and the writeback request record used
// by the register-file write arbiter and its holding slots.
package reg_arb_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned NREG   = 1 << ADDR_W;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic [NREG-1:0] addr_onehot(input logic              en,
                                                  input logic [ADDR_W-1:0] addr);
    logic [NREG-1:0] v;
    v = '0;
    if (en) v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry writeback holding slot with valid/ready handshake, clear-on-grant
// and an age bit telling whether this entry was captured before its peer's.
module wb_hold_slot
  import reg_arb_pkg::*;
(
  input  logic    clk,
  input  logic    RESET,
  input  logic    valid_i,
  input  wb_req_t req_i,
  output logic    ready_o,
  input  logic    grant_i,
  input  logic    peer_cap_i,
  input  logic    tie_old_i,
  output logic    cap_o,
  output logic    valid_o,
  output wb_req_t req_o,
  output logic    older_o,
  output logic    valid_d_o,
  output wb_req_t req_d_o
);

  logic    valid_q, valid_d;
  wb_req_t req_q, req_d;
  logic    older_q, older_d;

  always_comb begin
    ready_o = RESET & (~valid_q | grant_i);
    cap_o   = valid_i & ready_o;
    valid_d = valid_q;
    req_d   = req_q;
    older_d = older_q;
    // A fresh capture is younger than a held peer; on a same-edge capture
    // tie_old_i decides which of the two counts as older.
    if (cap_o) begin
      valid_d = 1'b1;
      req_d   = req_i;
      older_d = peer_cap_i & tie_old_i;
    end else begin
      if (grant_i)    valid_d = 1'b0;
      if (peer_cap_i) older_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!RESET) begin
      valid_q <= 1'b0;
      req_q   <= '0;
      older_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      req_q   <= req_d;
      older_q <= older_d;
    end
  end

  assign valid_o   = valid_q;
  assign req_o     = req_q;
  assign older_o   = older_q;
  assign valid_d_o = valid_d;
  assign req_d_o   = req_d;

endmodule

// File: rtl/reg_write_arbiter.sv
// Shares the register file write port between the ALU and load writeback
// paths: round-robin grant with same-address ordering, registered write stage.
module reg_write_arbiter
  import reg_arb_pkg::*;
(
  input  logic              clk,
  input  logic              RESET,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              WRITE,
  output logic [ADDR_W-1:0] INaddr,
  output logic [DATA_W-1:0] IN,
  output logic [NREG-1:0]   pending,
  output logic [7:0]        conflict_cnt
);

  wb_req_t alu_req, mem_req;
  wb_req_t alu_held, mem_held, alu_nxt, mem_nxt;
  logic    alu_v, mem_v, alu_v_nxt, mem_v_nxt;
  logic    alu_older, mem_older, alu_cap, mem_cap;
  logic    gnt_alu, gnt_mem, both_v;

  req_id_e           last_q, last_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NREG-1:0]   pending_q, pending_d;
  logic [7:0]        cnt_q, cnt_d;

  assign alu_req = '{addr: alu_addr, data: alu_data};
  assign mem_req = '{addr: mem_addr, data: mem_data};

  wb_hold_slot u_alu_slot (
    .clk        (clk),
    .RESET      (RESET),
    .valid_i    (alu_valid),
    .req_i      (alu_req),
    .ready_o    (alu_ready),
    .grant_i    (gnt_alu),
    .peer_cap_i (mem_cap),
    .tie_old_i  (1'b0),
    .cap_o      (alu_cap),
    .valid_o    (alu_v),
    .req_o      (alu_held),
    .older_o    (alu_older),
    .valid_d_o  (alu_v_nxt),
    .req_d_o    (alu_nxt)
  );

  // On a same-edge capture the load slot counts as older, so the ALU value
  // is the one left in the register.
  wb_hold_slot u_mem_slot (
    .clk        (clk),
    .RESET      (RESET),
    .valid_i    (mem_valid),
    .req_i      (mem_req),
    .ready_o    (mem_ready),
    .grant_i    (gnt_mem),
    .peer_cap_i (alu_cap),
    .tie_old_i  (1'b1),
    .cap_o      (mem_cap),
    .valid_o    (mem_v),
    .req_o      (mem_held),
    .older_o    (mem_older),
    .valid_d_o  (mem_v_nxt),
    .req_d_o    (mem_nxt)
  );

  assign both_v = alu_v & mem_v;

  always_comb begin
    gnt_alu = 1'b0;
    gnt_mem = 1'b0;
    if (both_v) begin
      if (alu_held.addr == mem_held.addr) begin
        if (mem_older && !alu_older) gnt_mem = 1'b1;
        else                         gnt_alu = 1'b1;
      end else if (last_q == REQ_MEM) begin
        gnt_alu = 1'b1;
      end else begin
        gnt_mem = 1'b1;
      end
    end else begin
      gnt_alu = alu_v;
      gnt_mem = mem_v;
    end
  end

  always_comb begin
    write_d = gnt_alu | gnt_mem;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    if (gnt_mem) begin
      waddr_d = mem_held.addr;
      wdata_d = mem_held.data;
      last_d  = REQ_MEM;
    end else if (gnt_alu) begin
      waddr_d = alu_held.addr;
      wdata_d = alu_held.data;
      last_d  = REQ_ALU;
    end
    cnt_d = cnt_q;
    if (both_v && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    pending_d = addr_onehot(alu_v_nxt, alu_nxt.addr)
              | addr_onehot(mem_v_nxt, mem_nxt.addr)
              | addr_onehot(write_d, waddr_d);
  end

  always_ff @(posedge clk) begin
    if (!RESET) begin
      write_q   <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      pending_q <= '0;
      cnt_q     <= '0;
      last_q    <= REQ_MEM;
    end else begin
      write_q   <= write_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
    end
  end

  assign WRITE        = write_q;
  assign INaddr       = waddr_q;
  assign IN           = wdata_q;
  assign pending      = pending_q;
  assign conflict_cnt = cnt_q;

endmodule
